uart_prog_loader: RTL and testbench

//  UART bootloader front end. It sits upstream of the core's program-memory write port
//  (PROGDI/PROGADD/PROG_WE/PROG_CLK). It receives 8N1 serial bytes on rx and pairs them

---
 rtl/uart_prog_loader.sv | 169 ++++++++++++++++
 tb/tb_uart_prog_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// UART bootloader front end: 8N1 bytes paired into little-endian words written to program memory.
// Latency: write setup one clk after the high byte's stop bit is sampled; strobe and hold follow.
// Backpressure: none; the line rate guarantees each 3-clk write finishes before the next byte.
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_CLKS = 5000000,
    parameter int ADDR_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [15:0]       DOUT,
    output logic [ADDR_W-1:0] PADD,
    output logic              wren,
    output logic              clock,
    output logic              busy,
    output logic              frame_err
);
    localparam int BIT_CW = $clog2(CLKS_PER_BIT);
    localparam int TO_W   = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [BIT_CW-1:0] BIT_LAST  = BIT_CW'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CW-1:0] HALF_LAST = BIT_CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TO_W-1:0]   TO_LIMIT  = TO_W'(TIMEOUT_CLKS);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic [1:0] {W_IDLE, W_SETUP, W_STROBE, W_HOLD} wr_state_t;

    rx_state_t         rx_state;
    wr_state_t         wr_state;
    logic              rx_meta;
    logic              rx_sync;
    logic              rx_prev;
    logic [BIT_CW-1:0] bit_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        rx_byte;
    logic              byte_valid;
    logic              phase_hi;
    logic [7:0]        lo_byte;
    logic [ADDR_W-1:0] addr;
    logic [TO_W-1:0]   to_cnt;
    logic              start_confirm;

    assign start_confirm = (rx_state == START) && (bit_cnt == HALF_LAST) && !rx_sync;

    // Receiver: the synchronizer presets high so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= START;
                        bit_cnt  <= '0;
                    end
                end
                START: begin
                    if (bit_cnt == HALF_LAST) begin
                        bit_cnt  <= '0;
                        bit_idx  <= '0;
                        rx_state <= rx_sync ? IDLE : DATA;
                    end else begin
                        bit_cnt <= bit_cnt + BIT_CW'(1);
                    end
                end
                DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        rx_byte <= {rx_sync, rx_byte[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            rx_state <= STOP;
                    end else begin
                        bit_cnt <= bit_cnt + BIT_CW'(1);
                    end
                end
                STOP: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt    <= '0;
                        byte_valid <= rx_sync;
                        frame_err  <= !rx_sync;
                        rx_state   <= IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + BIT_CW'(1);
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

    // Word assembly, write strobe sequencing and session timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            DOUT     <= '0;
            PADD     <= '0;
            wren     <= 1'b0;
            clock    <= 1'b0;
            busy     <= 1'b0;
            phase_hi <= 1'b0;
            lo_byte  <= '0;
            addr     <= '0;
            to_cnt   <= '0;
            wr_state <= W_IDLE;
        end else begin
            if (start_confirm)
                busy <= 1'b1;

            if (byte_valid || rx_state != IDLE)
                to_cnt <= '0;
            else if (busy && to_cnt != TO_LIMIT)
                to_cnt <= to_cnt + TO_W'(1);

            if (frame_err)
                phase_hi <= 1'b0;

            if (byte_valid) begin
                if (!phase_hi) begin
                    lo_byte  <= rx_byte;
                    phase_hi <= 1'b1;
                end else begin
                    DOUT     <= {rx_byte, lo_byte};
                    PADD     <= addr;
                    wren     <= 1'b1;
                    wr_state <= W_SETUP;
                    phase_hi <= 1'b0;
                end
            end

            case (wr_state)
                W_SETUP: begin
                    clock    <= 1'b1;
                    wr_state <= W_STROBE;
                end
                W_STROBE: begin
                    clock    <= 1'b0;
                    wr_state <= W_HOLD;
                end
                W_HOLD: begin
                    wren     <= 1'b0;
                    addr     <= addr + ADDR_W'(1);
                    wr_state <= W_IDLE;
                end
                default: ;
            endcase

            // A write in flight owns addr until its hold cycle completes.
            if (busy && to_cnt == TO_LIMIT && wr_state == W_IDLE && !byte_valid) begin
                busy     <= 1'b0;
                addr     <= '0;
                phase_hi <= 1'b0;
                to_cnt   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: serial bytes driven on rx, word writes checked against a queue model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_uart_prog_loader;
    localparam int CPB = 16;
    localparam int TO  = 600;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic [15:0]   DOUT;
    logic [AW-1:0] PADD;
    logic          wren;
    logic          clock;
    logic          busy;
    logic          frame_err;

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .rx(rx), .DOUT(DOUT), .PADD(PADD),
        .wren(wren), .clock(clock), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state: next word address, byte phase, pending low byte, expected writes.
    logic [AW+15:0] exp_q[$];
    logic [AW-1:0]  m_addr;
    logic           m_phase;
    logic [7:0]     m_lo;
    int             m_wr;
    int             exp_fe;

    // Observed by the compare process.
    int             n_fe;
    int             n_wr;
    logic [15:0]    lw_d;
    logic [AW-1:0]  lw_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input logic ok);
        if (!ok) begin
            m_phase = 1'b0;
            exp_fe++;
        end else if (!m_phase) begin
            m_lo    = b;
            m_phase = 1'b1;
        end else begin
            exp_q.push_back({m_addr, b, m_lo});
            m_addr  = m_addr + 1'b1;
            m_phase = 1'b0;
            m_wr++;
        end
    endtask

    task automatic model_restart();
        m_addr  = '0;
        m_phase = 1'b0;
    endtask

    // Model is updated before the stop bit, since the write lands mid stop bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        model_byte(b, stop_ok);
        rx = stop_ok;
        tick(CPB);
        rx = 1'b1;
        tick(4);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        tick(n);
        rst = 1'b0;
        model_restart();
    endtask

    task automatic monitor();
        int             wpos = 0;
        logic           fe_prev = 1'b0;
        logic [15:0]    cd = '0;
        logic [AW-1:0]  ca = '0;
        logic [AW+15:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                wpos    = 0;
                fe_prev = 1'b0;
            end else begin
                if (frame_err) begin
                    n_fe++;
                    chk("frame_err_width", 32'(fe_prev), 32'd0);
                end
                fe_prev = frame_err;
                case (wpos)
                    0: begin
                        if (wren) begin
                            if (exp_q.size() == 0) begin
                                n_vec++;
                                n_err++;
                                $display("FAIL unexpected_write: got DOUT=%h PADD=%0d, want no write (t=%0t)",
                                         DOUT, PADD, $time);
                            end else begin
                                e = exp_q.pop_front();
                                chk("wr_data", 32'(DOUT), 32'(e[15:0]));
                                chk("wr_addr", 32'(PADD), 32'(e[AW+15:16]));
                                chk("setup_clock", 32'(clock), 32'd0);
                            end
                            cd   = DOUT;
                            ca   = PADD;
                            wpos = 1;
                        end else begin
                            chk("idle_clock", 32'(clock), 32'd0);
                        end
                    end
                    1: begin
                        chk("strobe_clock", 32'(clock), 32'd1);
                        chk("strobe_wren", 32'(wren), 32'd1);
                        chk("strobe_data", 32'(DOUT), 32'(cd));
                        chk("strobe_addr", 32'(PADD), 32'(ca));
                        wpos = 2;
                    end
                    2: begin
                        chk("hold_clock", 32'(clock), 32'd0);
                        chk("hold_wren", 32'(wren), 32'd1);
                        chk("hold_data", 32'(DOUT), 32'(cd));
                        chk("hold_addr", 32'(PADD), 32'(ca));
                        wpos = 3;
                    end
                    default: begin
                        chk("release_wren", 32'(wren), 32'd0);
                        chk("release_clock", 32'(clock), 32'd0);
                        lw_d = cd;
                        lw_a = ca;
                        n_wr++;
                        wpos = 0;
                    end
                endcase
            end
        end
    endtask

    initial begin
        rst = 1'b1; rx = 1'b1;
        m_addr = '0; m_phase = 1'b0; m_lo = '0; m_wr = 0; exp_fe = 0;
        n_fe = 0; n_wr = 0; lw_d = '0; lw_a = '0;
        fork
            monitor();
        join_none

        // Reset state
        tick(4);
        @(negedge clk);
        chk("rst_dout", 32'(DOUT), 32'd0);
        chk("rst_padd", 32'(PADD), 32'd0);
        chk("rst_wren", 32'(wren), 32'd0);
        chk("rst_clock", 32'(clock), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        tick(4);

        // Glitch shorter than half a bit
        rx = 1'b0;
        tick(CPB / 4);
        rx = 1'b1;
        tick(3 * CPB);
        chk("glitch_busy", 32'(busy), 32'd0);
        chk("glitch_writes", 32'(n_wr), 32'd0);

        // Single word
        send_byte(8'h0C, 1'b1);
        send_byte(8'h94, 1'b1);
        tick(10);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_data", 32'(lw_d), 32'h940C);
        chk("t1_addr", 32'(lw_a), 32'd0);
        tick(TO + 100);
        chk("t1_timeout_busy", 32'(busy), 32'd0);
        model_restart();

        // Three consecutive words
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h03, 1'b1); send_byte(8'h00, 1'b1);
        tick(20);
        chk("t2_last_addr", 32'(lw_a), 32'd2);
        chk("t2_padd_hold", 32'(PADD), 32'd2);
        chk("t2_dout_hold", 32'(DOUT), 32'h0003);
        tick(TO + 100);
        model_restart();

        // Dangling low byte dropped by timeout
        send_byte(8'hAA, 1'b1);
        tick(TO + 100);
        chk("t3_busy_fall", 32'(busy), 32'd0);
        model_restart();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        tick(10);
        chk("t3_data", 32'(lw_d), 32'h2211);
        chk("t3_addr", 32'(lw_a), 32'd0);

        // Framing errors, alone and after a low byte
        send_byte(8'h55, 1'b0);
        send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
        send_byte(8'h77, 1'b1);
        send_byte(8'h66, 1'b0);
        send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
        tick(10);
        chk("t4_fe_count", 32'(n_fe), 32'(exp_fe));
        chk("t4_fe_literal", 32'(n_fe), 32'd2);
        chk("t4_data", 32'(lw_d), 32'h0201);
        chk("t4_addr", 32'(lw_a), 32'd2);

        // Reset between low and high byte
        send_byte(8'h5A, 1'b1);
        do_reset(2);
        tick(2);
        chk("t5_busy", 32'(busy), 32'd0);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        tick(10);
        chk("t5_data", 32'(lw_d), 32'h3412);
        chk("t5_addr", 32'(lw_a), 32'd0);

        // Address wrap with a 4-bit address
        do_reset(2);
        tick(4);
        for (int i = 0; i < 17; i++) begin
            send_byte(8'(i), 1'b1);
            send_byte(8'hA0, 1'b1);
        end
        tick(10);
        chk("t6_wrap_addr", 32'(lw_a), 32'd0);
        chk("t6_wrap_data", 32'(lw_d), 32'hA010);

        tick(10);
        chk("final_write_count", 32'(n_wr), 32'(m_wr));
        chk("final_pending", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
